// File: rtl/smc777_vid_pkg.sv
// smc777_vid_pkg: shared definitions for the SMC-777 character video fetch.
//   - attribute byte bit positions (fg/bg colour index, reverse, blink)
//   - fetch FSM state encoding
//   - per-cell sampled CRTC control struct
//   - GRB index -> R3G3B2 colour expansion
package smc777_vid_pkg;

  // Attribute byte layout
  localparam int A_FG    = 0;  // [2:0] foreground GRB index
  localparam int A_BG    = 3;  // [5:3] background GRB index
  localparam int A_REV   = 6;  // reverse video
  localparam int A_BLINK = 7;  // blink enable

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CODE,
    ST_ATTR,
    ST_FONT,
    ST_LATCH
  } fetch_st_t;

  // CRTC control sampled at the start of a cell
  typedef struct packed {
    logic       de;
    logic       cursor;
    logic       hs;
    logic       vs;
    logic [4:0] ra;
  } cell_ctl_t;

  // GRB index -> R3G3B2: each set bit fills its whole field
  function automatic logic [7:0] grb_expand(input logic [2:0] grb);
    return {{3{grb[1]}}, {3{grb[2]}}, {2{grb[0]}}};
  endfunction

endpackage

// File: rtl/smc777_pix_shifter.sv
// smc777_pix_shifter: per-cell pixel shifter and colour generator.
// Ports:
//   clk, reset      clock, async active-high reset
//   ce_pix          pixel enable, shifts the pattern left (MSB first)
//   load            cell boundary: load pattern/attr/cursor for the new cell
//   pat, attr       fetched font row and attribute byte for the new cell
//   cursor          cursor flag for the new cell
//   blink           current blink phase
//   de              delayed display enable; blanks video when low
//   video           R3G3B2 pixel colour
module smc777_pix_shifter
  import smc777_vid_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       ce_pix,
  input  logic       load,
  input  logic [7:0] pat,
  input  logic [7:0] attr,
  input  logic       cursor,
  input  logic       blink,
  input  logic       de,
  output logic [7:0] video
);

  logic [7:0] shift;
  logic [7:0] cur_attr;
  logic       cur_cursor;
  logic       pix;
  logic [2:0] idx;

  // load only ever coincides with ce_pix, so it takes priority over the shift
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shift      <= '0;
      cur_attr   <= '0;
      cur_cursor <= 1'b0;
    end else if (load) begin
      shift      <= pat;
      cur_attr   <= attr;
      cur_cursor <= cursor;
    end else if (ce_pix) begin
      shift <= {shift[6:0], 1'b0};
    end
  end

  // Blink blanks the glyph first; reverse and cursor still invert the result
  always_comb begin
    pix   = shift[7] & ~(cur_attr[A_BLINK] & blink);
    pix   = pix ^ cur_attr[A_REV] ^ cur_cursor;
    idx   = pix ? cur_attr[A_FG +: 3] : cur_attr[A_BG +: 3];
    video = de ? grb_expand(idx) : 8'h00;
  end

endmodule

// File: rtl/smc777_vid_fetch.sv
// smc777_vid_fetch: character-mode VRAM/font fetch and pixel output.
// Paces the CRTC with crtc_ce (one pulse per 8 ce_pix), fetches code and
// attribute from VRAM at the sampled CRTC address, looks up the font row and
// hands the result to the pixel shifter at the next cell boundary. DE/HS/VS
// carry the same one-cell delay as the pixels.
// Ports:
//   clk, reset                       clock, async active-high reset
//   ce_pix                           pixel clock enable
//   crtc_ce                          CRTC character clock enable (registered)
//   crtc_ma/ra/de/cursor/hsync/vsync CRTC outputs
//   vram_addr, vram_rd, vram_q       VRAM port, 1-clk read latency
//   font_addr, font_q                font ROM port, 1-clk read latency
//   video                            R3G3B2 pixel colour
//   de_out, hs_out, vs_out           timing delayed by one cell
module smc777_vid_fetch
  import smc777_vid_pkg::*;
#(
  parameter int MA_W      = 11,
  parameter int BLINK_BIT = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            ce_pix,
  output logic            crtc_ce,
  input  logic [MA_W-1:0] crtc_ma,
  input  logic [4:0]      crtc_ra,
  input  logic            crtc_de,
  input  logic            crtc_cursor,
  input  logic            crtc_hsync,
  input  logic            crtc_vsync,
  output logic [MA_W:0]   vram_addr,
  output logic            vram_rd,
  input  logic [7:0]      vram_q,
  output logic [10:0]     font_addr,
  input  logic [7:0]      font_q,
  output logic [7:0]      video,
  output logic            de_out,
  output logic            hs_out,
  output logic            vs_out
);

  localparam int FW = BLINK_BIT + 1;

  logic [2:0]      pc;
  logic            boundary;
  fetch_st_t       state;
  logic [MA_W-1:0] ma_r;
  cell_ctl_t       ctl;
  logic [7:0]      next_pat;
  logic [7:0]      next_attr;
  logic            next_cursor;
  logic            vs_d;
  logic [FW-1:0]   frame_cnt;

  assign boundary = ce_pix && (pc == 3'd7);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc          <= '0;
      crtc_ce     <= 1'b0;
      state       <= ST_IDLE;
      ma_r        <= '0;
      ctl         <= '0;
      vram_addr   <= '0;
      vram_rd     <= 1'b0;
      font_addr   <= '0;
      next_pat    <= '0;
      next_attr   <= '0;
      next_cursor <= 1'b0;
      de_out      <= 1'b0;
      hs_out      <= 1'b0;
      vs_out      <= 1'b0;
    end else begin
      crtc_ce <= boundary;
      if (ce_pix) pc <= pc + 3'd1;
      // Timing captured at the previous cell start lines up with its pixels
      if (boundary) begin
        de_out <= ctl.de;
        hs_out <= ctl.hs;
        vs_out <= ctl.vs;
      end
      // Outputs are registered on entry, so they hold for the named state
      case (state)
        ST_IDLE: if (boundary) begin
          state     <= ST_CODE;
          ma_r      <= crtc_ma;
          ctl       <= '{de: crtc_de, cursor: crtc_cursor, hs: crtc_hsync,
                         vs: crtc_vsync, ra: crtc_ra};
          vram_addr <= {crtc_ma, 1'b0};
          vram_rd   <= crtc_de;
        end
        ST_CODE: begin
          state     <= ST_ATTR;
          vram_addr <= {ma_r, 1'b1};
        end
        ST_ATTR: begin
          // vram_q carries the code byte here
          state     <= ST_FONT;
          vram_rd   <= 1'b0;
          font_addr <= {vram_q, ctl.ra[2:0]};
        end
        ST_FONT: begin
          state     <= ST_LATCH;
          next_attr <= vram_q;
        end
        ST_LATCH: begin
          // Rows 8..31 of a cell are blank; so is anything outside display
          state       <= ST_IDLE;
          next_pat    <= (ctl.de && ctl.ra[4:3] == 2'b00) ? font_q : 8'h00;
          next_cursor <= ctl.cursor;
          if (!ctl.de) next_attr <= '0;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Frame counter on vsync rising edge; one bit of it is the blink phase
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vs_d      <= 1'b0;
      frame_cnt <= '0;
    end else begin
      vs_d <= crtc_vsync;
      if (crtc_vsync && !vs_d) frame_cnt <= frame_cnt + FW'(1);
    end
  end

  smc777_pix_shifter u_shifter (
    .clk    (clk),
    .reset  (reset),
    .ce_pix (ce_pix),
    .load   (boundary),
    .pat    (next_pat),
    .attr   (next_attr),
    .cursor (next_cursor),
    .blink  (frame_cnt[BLINK_BIT]),
    .de     (de_out),
    .video  (video)
  );

endmodule
